// File: rtl/fetch_queue.sv
// Instruction-fetch front end: pipelined, credit-limited I-mem reads feeding a PC-tagged decode queue.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h6000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_en,
  input  logic [31:0] branch_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  input  logic        id_ready
);

  localparam int          PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int          OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      q_pc_q   [QUEUE_DEPTH];
  logic [31:0]      q_inst_q [QUEUE_DEPTH];

  logic        issue, accept, enq, pop, bypass;
  logic [31:0] in_use;

  // Slots already spoken for: queued words plus in-flight words that will be kept.
  assign in_use = 32'(count_q) + 32'(outst_q) - 32'(drop_q);

  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass = rst && imem_resp && !br_en && (count_q == '0) && (drop_q == '0);
`endif
    issue = rst && !br_en && (32'(outst_q) < 32'(MAX_OUTSTANDING))
            && (in_use < 32'(QUEUE_DEPTH));
    imem_rmask = issue ? 4'hF : 4'h0;
    imem_addr  = rst ? fetch_pc_q : RESET_PC;

    if (bypass) begin
      if_id_valid = 1'b1;
      if_id_pc    = resp_pc_q;
      if_id_inst  = imem_rdata;
    end else if (rst && (count_q != '0)) begin
      if_id_valid = 1'b1;
      if_id_pc    = q_pc_q[head_q];
      if_id_inst  = q_inst_q[head_q];
    end else begin
      if_id_valid = 1'b0;
      if_id_pc    = 32'h0;
      if_id_inst  = NOP;
    end

    accept = imem_resp && (drop_q == '0) && !br_en;
    pop    = if_id_valid && id_ready && !bypass;
    enq    = accept && !(bypass && id_ready);
  end

  always_comb begin
    fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = accept ? resp_pc_q + 32'd4 : resp_pc_q;
    outst_d    = outst_q + OUT_W'(issue) - OUT_W'(imem_resp);
    drop_d     = drop_q;
    if (imem_resp && (drop_q != '0)) begin
      drop_d = drop_q - OUT_W'(1);
    end
    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

    // Redirect wins: every word still in flight becomes stale and is dropped on arrival.
    if (br_en) begin
      fetch_pc_d = branch_pc;
      resp_pc_d  = branch_pc;
      drop_d     = outst_q - OUT_W'(imem_resp);
      head_d     = tail_q;
      tail_d     = tail_q;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && enq) begin
      q_pc_q[tail_q]   <= resp_pc_q;
      q_inst_q[tail_q] <= imem_rdata;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && imem_resp) begin
      assert (outst_q != '0) else $error("fetch_queue: response with nothing outstanding");
    end
    if (rst && enq && !pop) begin
      assert (count_q != CNT_W'(QUEUE_DEPTH)) else $error("fetch_queue: queue overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, redirect/reset sequences, and a
// randomized run checked against an in-order fetch/decode PC stream model.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h6000_0000;
  localparam int          MAXO     = 2;
`ifdef FETCH_BYPASS_EN
  localparam int          BYP      = 1;
`else
  localparam int          BYP      = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, br_en, imem_resp, if_id_valid, id_ready;
  logic [31:0] branch_pc, imem_addr, imem_rdata, if_id_pc, if_id_inst;
  logic [3:0]  imem_rmask;

  fetch_queue #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .br_en(br_en), .branch_pc(branch_pc),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct {
    logic        rdy;
    logic [3:0]  rmask;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  req_t        pend[$];
  vec_t        tbl[8];
  int          n_chk = 0, n_err = 0, cyc = 0, n_issue = 0, n_dec = 0;
  int          lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_issue = RESET_PC, exp_dec = RESET_PC;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_inst;
  logic [3:0]  s_rmask;
  logic [31:0] s_addr, s_pc, s_inst;
  logic        s_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs and the memory model, sample outputs, check against the stream model.
  task automatic step(input logic r, input logic br, input logic [31:0] bpc, input logic rdy);
    @(negedge clk);
    rst = r; br_en = br; branch_pc = bpc; id_ready = rdy;
    imem_resp = 1'b0; imem_rdata = $urandom;
    if (!r) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp  = 1'b1;
      imem_rdata = inst_of(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    s_rmask = imem_rmask; s_addr = imem_addr; s_valid = if_id_valid;
    s_pc = if_id_pc; s_inst = if_id_inst;
    if (!r) begin
      chk("rst_rmask", {28'h0, s_rmask}, 32'h0);
      chk("rst_valid", {31'h0, s_valid}, 32'h0);
      exp_issue = RESET_PC; exp_dec = RESET_PC; prev_hold = 1'b0;
    end else begin
      chk("imem_addr", s_addr, exp_issue);
      if (s_rmask != 4'h0 && s_rmask != 4'hF) chk("rmask_legal", {28'h0, s_rmask}, 32'h0);
      if (s_rmask == 4'hF) begin
        if (br) chk("no_issue_on_br", {28'h0, s_rmask}, 32'h0);
        pend.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_lo, lat_hi))});
        chk("max_outstanding", {31'h0, pend.size() > MAXO}, 32'h0);
        exp_issue = exp_issue + 32'd4;
        n_issue++;
      end
      if (prev_hold) begin
        chk("hold_valid", {31'h0, s_valid}, 32'h1);
        chk("hold_pc", s_pc, prev_pc);
        chk("hold_inst", s_inst, prev_inst);
      end
      if (s_valid && rdy) begin
        $display("dec cycle=%0d pc=%h inst=%h", cyc, s_pc, s_inst);
        chk("dec_pc", s_pc, exp_dec);
        chk("dec_inst", s_inst, inst_of(exp_dec));
        exp_dec = exp_dec + 32'd4;
        n_dec++;
      end
      prev_hold = s_valid && !rdy && !br;
      prev_pc = s_pc; prev_inst = s_inst;
      if (br) begin
        exp_issue = bpc; exp_dec = bpc;
      end
    end
    cyc++;
  endtask

  initial begin : main
    int          n0, guard, target;
    logic        brr, seen_issue;
    logic [31:0] bpc;
    rst = 1'b0; br_en = 1'b0; branch_pc = '0; imem_resp = 1'b0; imem_rdata = '0; id_ready = 1'b0;

    for (int k = 0; k < 8; k++) begin
      tbl[k].rdy   = 1'b1;
      tbl[k].rmask = 4'hF;
      tbl[k].addr  = RESET_PC + 32'(4 * k);
      tbl[k].valid = (k >= 2 - BYP);
      tbl[k].pc    = tbl[k].valid ? RESET_PC + 32'(4 * (k - 2 + BYP)) : 32'h0;
    end

    // Reset state
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_addr", s_addr, RESET_PC);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_inst", s_inst, 32'h0000_0013);

    // Reset release, 1-cycle memory, decode always ready
    lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 32'h0, tbl[k].rdy);
      chk($sformatf("tbl%0d_rmask", k), {28'h0, s_rmask}, {28'h0, tbl[k].rmask});
      chk($sformatf("tbl%0d_addr", k), s_addr, tbl[k].addr);
      chk($sformatf("tbl%0d_valid", k), {31'h0, s_valid}, {31'h0, tbl[k].valid});
      if (tbl[k].valid) chk($sformatf("tbl%0d_pc", k), s_pc, tbl[k].pc);
    end

    // Decode stalled: credits cap the queue at four entries, head holds
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    n0 = n_issue;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stall_issues", 32'(n_issue - n0), 32'd4);
    chk("stall_valid", {31'h0, s_valid}, 32'h1);
    chk("stall_head", s_pc, RESET_PC);

    // Mid-stream reset with a full queue
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mrst_addr", s_addr, RESET_PC);
    chk("mrst_rmask", {28'h0, s_rmask}, 32'h0);
    chk("mrst_valid", {31'h0, s_valid}, 32'h0);

    // Redirect with two requests in flight
    lat_lo = 3; lat_hi = 3;
    n0 = n_issue;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("two_inflight", 32'(n_issue - n0), 32'd2);
    step(1'b1, 1'b1, 32'h6000_0100, 1'b1);
    guard = 0; seen_issue = 1'b0;
    do begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_rmask == 4'hF && !seen_issue) begin
        chk("redir_issue", s_addr, 32'h6000_0100);
        seen_issue = 1'b1;
      end
      guard++;
    end while (!s_valid && guard < 30);
    chk("redir_dec_valid", {31'h0, s_valid}, 32'h1);
    chk("redir_dec_pc", s_pc, 32'h6000_0100);

    // Redirect in the same cycle as a response, 1-cycle memory
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h6000_0200, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("br_resp_rmask", {28'h0, s_rmask}, 32'hF);
    chk("br_resp_addr", s_addr, 32'h6000_0200);
    guard = 0;
    while (!s_valid && guard < 20) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      guard++;
    end
    chk("br_resp_dec_pc", s_pc, 32'h6000_0200);

    // Randomized run: variable latency, random decode stalls and redirects
    lat_lo = 1; lat_hi = 3;
    target = n_dec + 1000; guard = 0;
    while (n_dec < target && guard < 20000) begin
      brr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 7) == 0) bpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      else                           bpc = 32'h6000_1000 + 32'($urandom_range(0, 1023)) * 32'd4;
      step(1'b1, brr, bpc, ($urandom_range(0, 9) < 7));
      guard++;
    end
    chk("random_done", {31'h0, n_dec >= target}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
